// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// parity-mode constants and the bit-period calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Rounded clocks-per-bit so the baud error stays within half a cycle.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
// Pointers wrap modulo DEPTH; full/empty come from the count.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    output logic                         full,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a byte FIFO; frames are sent back-to-back
// while bytes remain queued.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 16,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              tx,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int            DIV       = baud_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int            BW        = $clog2(DIV + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic          fifo_full, fifo_empty, fifo_pop;
    logic [7:0]    fifo_rd_data;
    logic          baud_tick, parity_bit;
    logic [2:0]    next_idx;

    assign tx_ready = reset && !fifo_full;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_valid && tx_ready),
        .wr_data (tx_data),
        .full    (fifo_full),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_tick  = (baud_q == BAUD_LAST);
    assign next_idx   = bit_idx_q + 3'd1;
    assign parity_bit = (PARITY == PARITY_ODD) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = (state_q == ST_IDLE || baud_tick) ? '0 : baud_q + BW'(1);
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = shift_q[next_idx];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rd_data;
                            state_d  = ST_START;
                            tx_d     = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: three parity/stop configurations,
// serial-line decoder with a byte scoreboard on the no-parity instance.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic       rdy0, rdy1, rdy2, tx0, tx1, tx2, bsy0, bsy1, bsy2;
    logic [2:0] cnt0, cnt1, cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffered #(.CLK_FREQUENCY(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(4),
                       .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v0), .tx_ready(rdy0),
        .tx(tx0), .tx_busy(bsy0), .fifo_count(cnt0));
    uart_tx_buffered #(.CLK_FREQUENCY(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(4),
                       .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v1), .tx_ready(rdy1),
        .tx(tx1), .tx_busy(bsy1), .fifo_count(cnt1));
    uart_tx_buffered #(.CLK_FREQUENCY(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(4),
                       .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v2), .tx_ready(rdy2),
        .tx(tx2), .tx_busy(bsy2), .fifo_count(cnt2));

    // Every byte accepted by dut0 is expected on its line, in order.
    always @(posedge clk) if (v0 && rdy0) exp_q.push_back(tx_data);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int i);
        case (i) 0: return tx0; 1: return tx1; default: return tx2; endcase
    endfunction
    function automatic logic get_busy(input int i);
        case (i) 0: return bsy0; 1: return bsy1; default: return bsy2; endcase
    endfunction
    function automatic logic get_rdy(input int i);
        case (i) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
    endfunction
    function automatic logic [2:0] get_cnt(input int i);
        case (i) 0: return cnt0; 1: return cnt1; default: return cnt2; endcase
    endfunction

    task automatic set_valid(input int i, input logic val);
        case (i) 0: v0 = val; 1: v1 = val; default: v2 = val; endcase
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic push(input int inst, input logic [7:0] b, output int acc_cyc);
        logic got;
        got = 1'b0;
        acc_cyc = -1;
        tx_data = b;
        set_valid(inst, 1'b1);
        for (int t = 0; t < 400 && !got; t++) begin
            if (get_rdy(inst)) begin
                got = 1'b1;
                acc_cyc = cyc;
            end
            @(negedge clk);
        end
        set_valid(inst, 1'b0);
        chk($sformatf("push_accept_dut%0d", inst), got, 1'b1);
    endtask

    // Cycle-exact line check of one frame, starting just after the accept edge.
    task automatic check_frame(input int inst, input logic [7:0] b, input int par, input int stops);
        logic [11:0] fb;
        int nb;
        fb = '0;
        fb[8:1] = b;
        nb = 9;
        if (par != 0) begin
            fb[9] = (par == 1) ? ^b : ~^b;
            nb = 10;
        end
        for (int s = 0; s < stops; s++) begin
            fb[nb] = 1'b1;
            nb++;
        end
        chk($sformatf("lat_tx_dut%0d", inst), get_tx(inst), 1'b1);
        chk($sformatf("lat_busy_dut%0d", inst), get_busy(inst), 1'b0);
        chk($sformatf("lat_cnt_dut%0d", inst), get_cnt(inst), 3'd1);
        for (int k = 0; k < nb * 10; k++) begin
            @(negedge clk);
            chk($sformatf("line_dut%0d_c%0d", inst, k), get_tx(inst), fb[k/10]);
            chk($sformatf("busy_dut%0d_c%0d", inst, k), get_busy(inst), 1'b1);
        end
        @(negedge clk);
        chk($sformatf("end_tx_dut%0d", inst), get_tx(inst), 1'b1);
        chk($sformatf("end_busy_dut%0d", inst), get_busy(inst), 1'b0);
    endtask

    // Line decoder for dut0: samples mid-bit, pops the scoreboard per frame.
    logic [7:0] mb;
    bit         mok;
    initial forever begin
        @(negedge clk);
        if (mon_en && reset && tx0 === 1'b0) begin
            mok = 1'b1;
            for (int j = 1; j < 100; j++) begin
                @(negedge clk);
                if (!mon_en) begin
                    mok = 1'b0;
                    break;
                end
                if (j == 5) chk("mon_start", tx0, 1'b0);
                if (j >= 15 && j <= 85 && (j % 10) == 5) mb[(j-15)/10] = tx0;
                if (j == 95) chk("mon_stop", tx0, 1'b1);
            end
            if (mok) begin
                chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("sb_byte", mb, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int a, x;
    int acc[6];
    logic [2:0] exp_cnt[5];
    int fall_cyc;

    initial begin
        exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd2;
        exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd4;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx_dut%0d", i), get_tx(i), 1'b1);
            chk($sformatf("rst_busy_dut%0d", i), get_busy(i), 1'b0);
            chk($sformatf("rst_cnt_dut%0d", i), get_cnt(i), 3'd0);
            chk($sformatf("rst_rdy_dut%0d", i), get_rdy(i), 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rdy_after_release", rdy0, 1'b1);
        mon_en = 1'b1;

        // Single byte, then the two parity configurations
        push(0, 8'h55, a);
        check_frame(0, 8'h55, 0, 1);
        push(1, 8'h07, a);
        check_frame(1, 8'h07, 1, 1);
        push(2, 8'h07, a);
        check_frame(2, 8'h07, 2, 2);

        // Overfill: A1 drains at once, A2..A5 fill, A6 waits for a pop
        for (int i = 0; i < 6; i++) begin
            push(0, 8'hA1 + 8'(i), acc[i]);
            if (i < 5) chk($sformatf("fill_cnt_%0d", i), cnt0, exp_cnt[i]);
            if (i == 4) chk("fill_rdy_low", rdy0, 1'b0);
        end
        for (int i = 1; i < 5; i++)
            chk($sformatf("fill_acc_%0d", i), acc[i] - acc[0], i);
        chk("a6_acc_after_pop", acc[5] - acc[0], 102);
        fall_cyc = -1;
        for (int t = 0; t < 2000 && fall_cyc < 0; t++) begin
            if (!bsy0) fall_cyc = cyc;
            else @(negedge clk);
        end
        chk("burst_busy_len", fall_cyc - acc[0], 602);
        repeat (2) @(negedge clk);
        chk("burst_sb_drained", exp_q.size(), 0);

        // Reset during data bit 3 of 0xF0 with two bytes queued
        push(0, 8'hF0, a);
        push(0, 8'hAA, x);
        push(0, 8'hBB, x);
        chk("abort_cnt_queued", cnt0, 3'd2);
        while (cyc < a + 46) @(negedge clk);
        chk("abort_pre_bit3", tx0, 1'b0);
        chk("abort_pre_busy", bsy0, 1'b1);
        mon_en = 1'b0;
        reset = 1'b0;
        tx_data = 8'h33;
        v0 = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx0, 1'b1);
        chk("abort_busy", bsy0, 1'b0);
        chk("abort_cnt", cnt0, 3'd0);
        chk("abort_rdy", rdy0, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            chk($sformatf("post_abort_tx_c%0d", k), tx0, 1'b1);
            chk($sformatf("post_abort_busy_c%0d", k), bsy0, 1'b0);
        end
        chk("post_abort_cnt", cnt0, 3'd0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
